// File: rtl/min_tree_pipe.sv
// Pipelined masked argmin over N packed unsigned channels, one tree level per stage.
// Build option: define MIN_TREE_HIGH_TIE_EN to make equal live values resolve to the higher index.
module min_tree_pipe #(
  parameter int N = 5,
  parameter int W = 16,
  localparam int IW = (N < 3) ? 1 : $clog2(N),
  localparam int LV = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_bus,
  input  logic [N-1:0]    in_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_min,
  output logic [IW-1:0]   out_idx,
  output logic            out_none
);

  typedef struct packed {
    logic [W-1:0]  val;
    logic [IW-1:0] idx;
    logic          live;
  } node_t;

  localparam node_t RST_NODE = '{val: '0, idx: '0, live: 1'b1};

  // a is always the lower-index node, so "a wins" keeps channel-0 data when nothing is live
  function automatic node_t merge(input node_t a, input node_t b);
    logic take_b;
    take_b = 1'b0;
    if (a.live && b.live) begin
`ifdef MIN_TREE_HIGH_TIE_EN
      take_b = (b.val <= a.val);
`else
      take_b = (b.val < a.val);
`endif
    end else begin
      take_b = b.live;
    end
    return take_b ? b : a;
  endfunction

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar j = 0; j <= LV; j++) begin : g_lvl
    localparam int C = (N + (1 << j) - 1) >> j;
    logic v;

    if (j == 0) begin : g_vin
      assign v = in_valid;
    end else begin : g_vreg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= 1'b0;
        end else if (!stall) begin
          v <= g_lvl[j-1].v;
        end
      end
    end

    for (genvar i = 0; i < C; i++) begin : g_n
      node_t q;

      if (j == 0) begin : g_leaf
        assign q = '{val: in_bus[i*W +: W], idx: IW'(i), live: in_mask[i]};
      end else begin : g_int
        localparam int P = (N + (1 << (j - 1)) - 1) >> (j - 1);
        node_t d;

        if (2 * i + 1 < P) begin : g_m
          assign d = merge(g_lvl[j-1].g_n[2*i].q, g_lvl[j-1].g_n[2*i+1].q);
        end else begin : g_p
          assign d = g_lvl[j-1].g_n[2*i].q;
        end

        // data only moves with a valid word, so idle cycles leave the last result in place
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            q <= RST_NODE;
          end else if (!stall && g_lvl[j-1].v) begin
            q <= d;
          end
        end
      end
    end
  end

  node_t root;

  assign root      = g_lvl[LV].g_n[0].q;
  assign out_valid = g_lvl[LV].v;
  assign out_min   = root.val;
  assign out_idx   = root.idx;
  assign out_none  = ~root.live;

endmodule

// File: tb/tb_min_tree_pipe.sv
// Directed bench for min_tree_pipe: N=5/W=16 and N=2/W=8 instances.
// Tie-break expectations follow MIN_TREE_HIGH_TIE_EN.
module tb_min_tree_pipe;

`ifdef MIN_TREE_HIGH_TIE_EN
  localparam int TIE5 = 3;
  localparam int TIE2 = 1;
`else
  localparam int TIE5 = 1;
  localparam int TIE2 = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v5 = 1'b0;
  logic        rdy5;
  logic [79:0] bus5 = '0;
  logic [4:0]  m5 = '0;
  logic        ov5;
  logic        ordy5 = 1'b1;
  logic [15:0] min5;
  logic [2:0]  idx5;
  logic        none5;

  logic        v2 = 1'b0;
  logic        rdy2;
  logic [15:0] bus2 = '0;
  logic [1:0]  m2 = '0;
  logic        ov2;
  logic        ordy2 = 1'b1;
  logic [7:0]  min2;
  logic [0:0]  idx2;
  logic        none2;

  int cmps = 0;
  int errs = 0;

  always #5 clk = ~clk;

  min_tree_pipe #(.N(5), .W(16)) u5 (
    .clk(clk), .rst(rst),
    .in_valid(v5), .in_ready(rdy5),
    .in_bus(bus5), .in_mask(m5),
    .out_valid(ov5), .out_ready(ordy5),
    .out_min(min5), .out_idx(idx5), .out_none(none5)
  );

  min_tree_pipe #(.N(2), .W(8)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(v2), .in_ready(rdy2),
    .in_bus(bus2), .in_mask(m2),
    .out_valid(ov2), .out_ready(ordy2),
    .out_min(min2), .out_idx(idx2), .out_none(none2)
  );

  function automatic logic [79:0] pk5(input logic [15:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic res5(input string tag, input int mn, input int ix, input int nn);
    chk({tag, ".valid"}, 32'(ov5), 1);
    chk({tag, ".min"}, 32'(min5), 32'(mn));
    chk({tag, ".idx"}, 32'(idx5), 32'(ix));
    chk({tag, ".none"}, 32'(none5), 32'(nn));
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst.valid5", 32'(ov5), 0);
    chk("rst.min5", 32'(min5), 0);
    chk("rst.idx5", 32'(idx5), 0);
    chk("rst.none5", 32'(none5), 0);
    chk("rst.valid2", 32'(ov2), 0);
    chk("rst.none2", 32'(none2), 0);
    rst = 1'b0;
    #1;
    chk("rst.ready5", 32'(rdy5), 1);
    chk("rst.ready2", 32'(rdy2), 1);

    // 1: full mask, tie between ch1 and ch3, exact 3-edge latency
    bus5 = pk5(300, 120, 450, 120, 999);
    m5 = 5'b11111;
    v5 = 1'b1;
    tick();
    v5 = 1'b0;
    chk("t1.lat1", 32'(ov5), 0);
    tick();
    chk("t1.lat2", 32'(ov5), 0);
    tick();
    res5("t1", 120, TIE5, 0);
    tick();
    chk("t1.drain", 32'(ov5), 0);

    // 2: ch1 masked, then all masked back-to-back
    m5 = 5'b11101;
    v5 = 1'b1;
    tick();
    m5 = 5'b00000;
    tick();
    v5 = 1'b0;
    tick();
    res5("t2a", 120, 3, 0);
    tick();
    res5("t2b", 300, 0, 1);
    tick();
    chk("t2.drain", 32'(ov5), 0);

    // 3: 8-word stream, one result per cycle
    m5 = 5'b11111;
    bus5 = pk5(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
    v5 = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t < 8) bus5 = pk5(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'(t));
      else v5 = 1'b0;
      if (t >= 3) res5($sformatf("t3.w%0d", t - 3), t - 3, 4, 0);
    end
    tick();
    chk("t3.drain", 32'(ov5), 0);

    // 4: back-pressure on word 0 for 5 cycles
    bus5 = pk5(16'hFFFF, 16'hFFFF, 10, 16'hFFFF, 16'hFFFF);
    v5 = 1'b1;
    tick();
    bus5 = pk5(16'hFFFF, 16'hFFFF, 11, 16'hFFFF, 16'hFFFF);
    tick();
    bus5 = pk5(16'hFFFF, 16'hFFFF, 12, 16'hFFFF, 16'hFFFF);
    tick();
    ordy5 = 1'b0;
    bus5 = pk5(16'hFFFF, 16'hFFFF, 13, 16'hFFFF, 16'hFFFF);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4.stall%0d.ready", c), 32'(rdy5), 0);
      res5($sformatf("t4.stall%0d", c), 10, 2, 0);
      tick();
    end
    ordy5 = 1'b1;
    #1;
    chk("t4.release.ready", 32'(rdy5), 1);
    tick();
    v5 = 1'b0;
    res5("t4.w1", 11, 2, 0);
    tick();
    res5("t4.w2", 12, 2, 0);
    tick();
    res5("t4.w3", 13, 2, 0);
    tick();
    chk("t4.drain", 32'(ov5), 0);

    // 5: async reset with a result at the root and two words in flight
    bus5 = pk5(16'hFFFF, 5, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    v5 = 1'b1;
    tick();
    tick();
    tick();
    v5 = 1'b0;
    chk("t5.pre", 32'(ov5), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5.async", 32'(ov5), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t5.flush%0d", c), 32'(ov5), 0);
    end
    bus5 = pk5(16'hFFFF, 16'hFFFF, 16'hFFFF, 42, 16'hFFFF);
    v5 = 1'b1;
    tick();
    v5 = 1'b0;
    tick();
    chk("t5.lat2", 32'(ov5), 0);
    tick();
    res5("t5.new", 42, 3, 0);

    // 6: N=2 single-stage instance
    bus2 = {8'd7, 8'd7};
    m2 = 2'b11;
    v2 = 1'b1;
    tick();
    chk("t6a.valid", 32'(ov2), 1);
    chk("t6a.min", 32'(min2), 7);
    chk("t6a.idx", 32'(idx2), TIE2);
    bus2 = {8'd0, 8'd255};
    tick();
    chk("t6b.min", 32'(min2), 0);
    chk("t6b.idx", 32'(idx2), 1);
    bus2 = {8'd9, 8'd3};
    m2 = 2'b10;
    tick();
    chk("t6c.min", 32'(min2), 9);
    chk("t6c.idx", 32'(idx2), 1);
    chk("t6c.none", 32'(none2), 0);
    m2 = 2'b00;
    tick();
    v2 = 1'b0;
    chk("t6d.none", 32'(none2), 1);
    chk("t6d.min", 32'(min2), 3);
    tick();
    chk("t6.drain", 32'(ov2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
